// File: rtl/alu_muldiv_control_pkg.sv
// Shared ALU op/control codes, funct field values, and muldiv FSM states
// for the ALU control decoder and its iterative multiply/divide engine.
package alu_muldiv_control_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;

    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_SLT  = 4'b0111;
    localparam logic [3:0] CTL_SLTU = 4'b1000;
    localparam logic [3:0] CTL_NOR  = 4'b1100;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_e;

    function automatic logic [3:0] alu_control(input logic [1:0] op, input logic [5:0] funct);
        logic [3:0] ctl;
        ctl = CTL_AND;
        case (op)
            OP_ADD:   ctl = CTL_ADD;
            OP_SUB:   ctl = CTL_SUB;
            OP_RTYPE: begin
                case (funct)
                    F_ADD:   ctl = CTL_ADD;
                    F_SUB:   ctl = CTL_SUB;
                    F_AND:   ctl = CTL_AND;
                    F_OR:    ctl = CTL_OR;
                    F_NOR:   ctl = CTL_NOR;
                    F_SLT:   ctl = CTL_SLT;
                    F_SLTU:  ctl = CTL_SLTU;
                    default: ctl = CTL_AND;
                endcase
            end
            default:  ctl = CTL_AND;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/alu_muldiv_control_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider core with sign fix-up.
// MULDIV_EARLY_EXIT_EN: finish a multiply as soon as the remaining multiplier bits are zero.
module alu_muldiv_control_muldiv_iter
    import alu_muldiv_control_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             finish_o,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o,
    output logic             div_zero_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] prod_q, mcand_q, prod_fix;
    logic [WIDTH-1:0]   mplier_q, rem_q, quo_q, dvsr_q, a_raw_q;
    logic               neg_a_q, neg_b_q, sgn_q, is_div_q, bzero_q;
    logic [WIDTH-1:0]   mag_a, mag_b, rem_next, diff, quo_fix, rem_fix;
    logic [WIDTH:0]     trial;
    logic               ge, last;

    assign mag_a = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign mag_b = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

    // Restoring step: the true difference always fits WIDTH bits whenever it is kept.
    assign trial    = {rem_q, quo_q[WIDTH-1]};
    assign ge       = trial[WIDTH] || (trial[WIDTH-1:0] >= dvsr_q);
    assign diff     = trial[WIDTH-1:0] - dvsr_q;
    assign rem_next = ge ? diff : trial[WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            a_raw_q  <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            sgn_q    <= 1'b0;
            is_div_q <= 1'b0;
            bzero_q  <= 1'b0;
        end else if (load_i) begin
            cnt_q    <= CW'(WIDTH);
            prod_q   <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, mag_a};
            mplier_q <= mag_b;
            rem_q    <= '0;
            quo_q    <= mag_a;
            dvsr_q   <= mag_b;
            a_raw_q  <= a_i;
            neg_a_q  <= is_signed_i && a_i[WIDTH-1];
            neg_b_q  <= is_signed_i && b_i[WIDTH-1];
            sgn_q    <= is_signed_i;
            is_div_q <= is_div_i;
            bzero_q  <= (b_i == '0);
        end else if (step_i) begin
            cnt_q <= cnt_q - CW'(1);
            if (is_div_q) begin
                rem_q <= rem_next;
                quo_q <= {quo_q[WIDTH-2:0], ge};
            end else begin
                if (mplier_q[0]) begin
                    prod_q <= prod_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
        end
    end

    assign last = (cnt_q == CW'(1));

`ifdef MULDIV_EARLY_EXIT_EN
    assign finish_o = last || (!is_div_q && (mplier_q == '0));
`else
    assign finish_o = last;
`endif

    assign prod_fix = (sgn_q && (neg_a_q ^ neg_b_q)) ? -prod_q : prod_q;
    assign quo_fix  = (sgn_q && (neg_a_q ^ neg_b_q)) ? -quo_q : quo_q;
    assign rem_fix  = (sgn_q && neg_a_q) ? -rem_q : rem_q;

    always_comb begin
        res_hi_o = prod_fix[2*WIDTH-1:WIDTH];
        res_lo_o = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (bzero_q) begin
                res_hi_o = a_raw_q;
                res_lo_o = '1;
            end else begin
                res_hi_o = rem_fix;
                res_lo_o = quo_fix;
            end
        end
    end

    assign div_zero_o = is_div_q && bzero_q;

endmodule

// File: rtl/alu_muldiv_control.sv
// ALU control decoder plus muldiv handshake FSM and HI/LO registers.
// Early-exit multiply is selected inside the core by MULDIV_EARLY_EXIT_EN.
module alu_muldiv_control
    import alu_muldiv_control_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       op,
    input  logic [5:0]       funct,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    state_e           state_q, state_d;
    logic             is_rtype, is_mul, is_div, is_mthi, is_mtlo, is_signed, accept;
    logic             load, step, fix, finish, res_div_zero;
    logic [WIDTH-1:0] hi_q, lo_q, res_hi, res_lo;
    logic             div_zero_q;

    assign control = alu_control(op, funct);

    assign is_rtype  = (op == OP_RTYPE);
    assign is_mul    = is_rtype && ((funct == F_MULT) || (funct == F_MULTU));
    assign is_div    = is_rtype && ((funct == F_DIV) || (funct == F_DIVU));
    assign is_mthi   = is_rtype && (funct == F_MTHI);
    assign is_mtlo   = is_rtype && (funct == F_MTLO);
    assign is_signed = (funct == F_MULT) || (funct == F_DIV);
    assign accept    = (state_q == ST_IDLE) && start && (is_mul || is_div || is_mthi || is_mtlo);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_mul) begin
                    load    = 1'b1;
                    state_d = ST_MUL;
                end else if (accept && is_div) begin
                    load    = 1'b1;
                    state_d = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                step = 1'b1;
                if (finish) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                fix     = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    alu_muldiv_control_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clock      (clock),
        .reset      (reset),
        .load_i     (load),
        .step_i     (step),
        .is_div_i   (is_div),
        .is_signed_i(is_signed),
        .a_i        (a),
        .b_i        (b),
        .finish_o   (finish),
        .res_hi_o   (res_hi),
        .res_lo_o   (res_lo),
        .div_zero_o (res_div_zero)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            if (fix) begin
                hi_q       <= res_hi;
                lo_q       <= res_lo;
                div_zero_q <= res_div_zero;
            end else if (accept) begin
                div_zero_q <= 1'b0;
                if (is_mthi) begin
                    hi_q <= a;
                end
                if (is_mtlo) begin
                    lo_q <= a;
                end
            end
        end
    end

    assign busy     = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
    assign done     = (state_q == ST_DONE);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_muldiv_control.sv
// Self-checking bench for alu_muldiv_control (WIDTH=32) against an arithmetic reference model.
module tb_alu_muldiv_control;

    localparam int W = 32;

    localparam logic [5:0] T_MULT  = 6'b011000;
    localparam logic [5:0] T_MULTU = 6'b011001;
    localparam logic [5:0] T_DIV   = 6'b011010;
    localparam logic [5:0] T_DIVU  = 6'b011011;
    localparam logic [5:0] T_MTHI  = 6'b010001;
    localparam logic [5:0] T_MTLO  = 6'b010011;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   op;
    logic [5:0]   funct;
    logic         start;
    logic [W-1:0] a, b;
    logic [3:0]   control;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    alu_muldiv_control #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .op(op), .funct(funct), .start(start),
        .a(a), .b(b), .control(control), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    function automatic logic [3:0] ref_ctl(input logic [1:0] o, input logic [5:0] f);
        if (o == 2'b00) return 4'b0010;
        if (o == 2'b01) return 4'b0110;
        if (o == 2'b11) return 4'b0000;
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b100111: return 4'b1100;
            6'b101010: return 4'b0111;
            6'b101011: return 4'b1000;
            default:   return 4'b0000;
        endcase
    endfunction

    // Returns {hi, lo}.
    function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, rm;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (f == T_MULTU) begin
            r = {32'h0, x} * {32'h0, y};
        end else if (f == T_MULT) begin
            r = 64'(sx * sy);
        end else if (y == 32'h0) begin
            r = {x, 32'hFFFF_FFFF};
        end else if (f == T_DIVU) begin
            r = {x % y, x / y};
        end else begin
            q  = sx / sy;
            rm = sx % sy;
            r  = {rm[31:0], q[31:0]};
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [5:0] f, input logic [31:0] y);
`ifdef MULDIV_EARLY_EXIT_EN
        logic [31:0] mag;
        int bl;
        if (f == T_MULT || f == T_MULTU) begin
            mag = (f == T_MULT && y[31]) ? -y : y;
            bl = 0;
            for (int i = 0; i < 32; i++) if (mag[i]) bl = i + 1;
            return (bl == 32) ? 34 : bl + 3;
        end
`endif
        return (f == 6'b111111) ? 0 : 34;
    endfunction

    // Launches one muldiv op, optionally re-asserts start at cycle restart_at,
    // and reports the done cycle, pulse count and busy-shape violations.
    task automatic do_op(input logic [5:0] f, input logic [31:0] aa, input logic [31:0] bb,
                         input int restart_at, output int done_at, output int pulses, output int busy_err);
        op = 2'b10; funct = f; a = aa; b = bb; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        done_at = -1; pulses = 0; busy_err = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == restart_at) begin
                start = 1'b1; a = ~aa; b = bb + 32'd1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = k;
                if (busy !== 1'b0) busy_err++;
            end else if (done_at < 0) begin
                if (busy !== 1'b1) busy_err++;
            end else if (busy !== 1'b0) begin
                busy_err++;
            end
            if (done_at > 0 && k >= done_at + 2) break;
            @(posedge clock); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; op = 2'b00; funct = 6'h0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
        checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_control();
        logic [1:0] dop [5] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b00};
        logic [5:0] dfn [5] = '{6'b100010, 6'b100111, 6'b111111, 6'b100000, 6'b100010};
        logic [3:0] dex [5] = '{4'b0110, 4'b1100, 4'b0000, 4'b0000, 4'b0010};
        logic [5:0] fl  [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b101011};
        for (int i = 0; i < 5; i++) begin
            op = dop[i]; funct = dfn[i]; #1;
            checks++;
            if (control !== dex[i]) begin
                errors++; $display("FAIL control_directed[%0d]: got %b expected %b", i, control, dex[i]);
            end
        end
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            funct = ($urandom_range(0, 1) == 1) ? fl[$urandom_range(0, 6)] : 6'($urandom);
            #1;
            checks++;
            if (control !== ref_ctl(op, funct)) begin
                errors++; $display("FAIL control_random op=%b funct=%b: got %b expected %b", op, funct, control, ref_ctl(op, funct));
            end
        end
        op = 2'b00; funct = 6'h0;
        @(posedge clock); #1;
    endtask

    task automatic test_directed_ops();
        logic [5:0]  tf [6] = '{T_MULTU, T_MULT, T_DIV, T_DIV, T_DIVU, T_DIV};
        logic [31:0] ta [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFF7, 32'h0000_1234};
        logic [31:0] tb [6] = '{32'd2, 32'd5, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [63:0] e;
        logic edz;
        int d, p, be;
        for (int i = 0; i < 6; i++) begin
            do_op(tf[i], ta[i], tb[i], 0, d, p, be);
            e = ref_op(tf[i], ta[i], tb[i]);
            edz = (tf[i] == T_DIV || tf[i] == T_DIVU) && (tb[i] == 32'h0);
            checks++; if (d != exp_lat(tf[i], tb[i])) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, d, exp_lat(tf[i], tb[i])); end
            checks++; if (p != 1) begin errors++; $display("FAIL dir_pulses[%0d]: got %0d expected 1", i, p); end
            checks++; if (be != 0) begin errors++; $display("FAIL dir_busy[%0d]: got %0d bad cycles expected 0", i, be); end
            checks++; if (hi !== e[63:32]) begin errors++; $display("FAIL dir_hi[%0d]: got %h expected %h", i, hi, e[63:32]); end
            checks++; if (lo !== e[31:0]) begin errors++; $display("FAIL dir_lo[%0d]: got %h expected %h", i, lo, e[31:0]); end
            checks++; if (div_zero !== edz) begin errors++; $display("FAIL dir_div_zero[%0d]: got %b expected %b", i, div_zero, edz); end
        end
    endtask

    // Runs right after a divide by zero, so div_zero starts at 1 and hi holds 0x1234.
    task automatic test_mt();
        logic [31:0] r;
        op = 2'b10; funct = T_MTLO; a = 32'd5; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        checks++; if (lo !== 32'd5) begin errors++; $display("FAIL mtlo_lo: got %h expected 5", lo); end
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mtlo_hi_kept: got %h expected 1234", hi); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL mtlo_div_zero_clear: got %b expected 0", div_zero); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_handshake: got busy=%b done=%b expected 0 0", busy, done); end
        r = $urandom;
        funct = T_MTHI; a = r; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        checks++; if (hi !== r) begin errors++; $display("FAIL mthi_hi: got %h expected %h", hi, r); end
        checks++; if (lo !== 32'd5) begin errors++; $display("FAIL mthi_lo_kept: got %h expected 5", lo); end
        @(posedge clock); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_handshake: got busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_ignored_start();
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        op = 2'b10; funct = 6'b100000; a = $urandom; b = $urandom; start = 1'b1;
        repeat (3) @(posedge clock);
        op = 2'b00; funct = T_MULT;
        repeat (3) @(posedge clock);
        #1; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_busy: got %b expected 0", busy); end
        checks++; if (hi !== h0 || lo !== l0) begin errors++; $display("FAIL ignored_hold: got %h_%h expected %h_%h", hi, lo, h0, l0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x, y;
        logic [63:0] e;
        int d, p, be;
        x = $urandom; y = $urandom;
        do_op(T_MULTU, x, y, 5, d, p, be);
        e = ref_op(T_MULTU, x, y);
        checks++; if (p != 1) begin errors++; $display("FAIL b2b_pulses: got %0d expected 1", p); end
        checks++; if (d != exp_lat(T_MULTU, y)) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", d, exp_lat(T_MULTU, y)); end
        checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL b2b_result: got %h_%h expected %h", hi, lo, e); end
    endtask

    task automatic test_random_ops();
        logic [5:0] fl [4] = '{T_MULT, T_MULTU, T_DIV, T_DIVU};
        logic [5:0] f;
        logic [31:0] x, y;
        logic [63:0] e;
        logic edz;
        int d, p, be;
        for (int i = 0; i < 24; i++) begin
            f = fl[$urandom_range(0, 3)];
            x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 3))
                0:       y = 32'h0;
                1:       y = 32'($urandom_range(0, 15));
                2:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            do_op(f, x, y, 0, d, p, be);
            e = ref_op(f, x, y);
            edz = (f == T_DIV || f == T_DIVU) && (y == 32'h0);
            checks++; if (d != exp_lat(f, y)) begin errors++; $display("FAIL rnd_latency f=%b a=%h b=%h: got %0d expected %0d", f, x, y, d, exp_lat(f, y)); end
            checks++; if (p != 1 || be != 0) begin errors++; $display("FAIL rnd_handshake f=%b: got pulses=%0d busy_err=%0d expected 1 0", f, p, be); end
            checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL rnd_result f=%b a=%h b=%h: got %h_%h expected %h", f, x, y, hi, lo, e); end
            checks++; if (div_zero !== edz) begin errors++; $display("FAIL rnd_div_zero f=%b b=%h: got %b expected %b", f, y, div_zero, edz); end
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        op = 2'b10; funct = T_DIV; a = 32'h7654_3210; b = 32'd3; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (hi !== '0 || lo !== '0) begin errors++; $display("FAIL abort_hilo: got %h_%h expected 0_0", hi, lo); end
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) pulses++;
            @(posedge clock); #1;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_control();
        test_directed_ops();
        test_mt();
        test_ignored_start();
        test_back_to_back();
        test_random_ops();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
